clk_switch_ctrl: RTL and testbench
==================================

// Module: clk_switch_ctrl
// PURPOSE
//  Sequencer for the glitch-free two-input clock switch. Runs on an always-on
//  control clock and accepts switch requests over a valid/ready handshake.
//  Checks that the target clock is alive, drives the switch select, then waits
//  a settle window before reporting completion or error. Holds the only writer
//  of the switch select line.
// PARAMETERS
//  SETTLE_CYCLES  16  clk cycles to wait after select change (>=1; integrator sets >= 6 periods of slowest switched clock)
//  ALIVE_TIMEOUT  64  max clk cycles in CHECK waiting for target alive (>=1)
// PORTS
//  clk         in   1  control clock, always running
//  rst         in   1  synchronous reset, active-high
//  req_valid   in   1  switch request valid
//  req_sel     in   1  requested source: 1 = clk1, 0 = clk2
//  req_ready   out  1  high only in IDLE; request accepted when valid & ready
//  clk1_alive  in   1  clk1 activity flag, already synchronous to clk
//  clk2_alive  in   1  clk2 activity flag, already synchronous to clk
//  sel_clk1    out  1  registered select to clock switch (1 = clk1)
//  cur_sel     out  1  committed source after last successful switch
//  busy        out  1  high in every state except IDLE
//  done        out  1  one-cycle pulse at end of every accepted request
//  err         out  1  valid with done; 1 = request failed or degraded
// BEHAVIOUR
//  Reset: state IDLE, sel_clk1=1, cur_sel=1, req_ready=1, busy=0, done=0,
//   err=0, counter=0. Reset mid-operation aborts; sel_clk1 returns to 1.
//  States: IDLE, CHECK, SWITCH, SETTLE, DONE. Counter width sized internally
//   to max(SETTLE_CYCLES, ALIVE_TIMEOUT); never wraps.
//  IDLE: on valid&ready latch tgt=req_sel. If tgt==cur_sel -> DONE (no-op,
//   err=0, sel unchanged); else -> CHECK, counter cleared.
//  CHECK: if target alive (tgt?clk1_alive:clk2_alive) -> SWITCH. Else
//   counter++; on count reaching ALIVE_TIMEOUT-1 with alive low -> DONE, err=1,
//   sel_clk1 and cur_sel unchanged.
//  SWITCH: one cycle; sel_clk1<=tgt (new value visible first SETTLE cycle);
//   counter cleared -> SETTLE.
//  SETTLE: counter++ each cycle; after SETTLE_CYCLES cycles -> DONE and
//   cur_sel<=tgt. If target alive is low in any SETTLE cycle, set sticky
//   fail flag -> err=1 at done; select is NOT reverted, cur_sel still updates.
//  DONE: done=1 for exactly one cycle with err; -> IDLE. Fail flag cleared.
//  Latency (alive already high): accept at edge N; CHECK N+1, SWITCH N+2,
//   sel_clk1 changes N+3, done high at cycle N+3+SETTLE_CYCLES.
//  No-op latency: done high the cycle after acceptance.
//  req_valid while busy: ignored, not queued; requester holds valid.
//  done/err deassert every cycle other than DONE; err=0 whenever done=0.
//  Simultaneous req_valid and rst: reset wins, request dropped.
// TESTING
//  1 After rst, req_sel=0 valid 1 cycle, clk2_alive=1 -> sel_clk1 1->0 at
//    N+3, done&!err at N+19 (SETTLE_CYCLES=16), cur_sel=0, busy low after.
//  2 cur_sel=1, request sel=1 -> done=1, err=0 next cycle, sel_clk1 stays 1,
//    no SETTLE entered.
//  3 clk2_alive=0, request sel=0 -> CHECK 64 cycles, done&err, sel_clk1=1,
//    cur_sel=1; repeat with alive rising at cycle 10 -> success path.
//  4 Drop clk1_alive for 1 cycle mid-SETTLE on switch to clk1 -> done&err,
//    sel_clk1=1, cur_sel=1.
//  5 Hold req_valid continuously with alternating req_sel -> only accepted
//    in IDLE, req_ready=0 while busy, one done per acceptance.
//  6 Assert rst during SETTLE after switch to clk2 -> next cycle sel_clk1=1,
//    cur_sel=1, IDLE, no done pulse.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Control-clock sequencer for a glitch-free two-input clock switch: it checks that the
// target clock is alive, moves the select, waits out a settle window, then reports done/err.
module clk_switch_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ALIVE_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic clk1_alive,
    input  logic clk2_alive,
    output logic sel_clk1,
    output logic cur_sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int MAX_CNT = (SETTLE_CYCLES > ALIVE_TIMEOUT) ? SETTLE_CYCLES : ALIVE_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ALIVE_TIMEOUT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] SWITCH = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          tgt_reg, tgt_next;
    logic          sel_reg, sel_next;
    logic          cur_reg, cur_next;
    logic          fail_reg, fail_next;
    logic          tgt_alive;

    assign tgt_alive = tgt_reg ? clk1_alive : clk2_alive;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tgt_next   = tgt_reg;
        sel_next   = sel_reg;
        cur_next   = cur_reg;
        fail_next  = fail_reg;
        case (state_reg)
            IDLE: begin
                fail_next = 1'b0;
                if (req_valid) begin
                    tgt_next = req_sel;
                    // Requesting the already committed source completes as a no-op.
                    if (req_sel == cur_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = CHECK;
                        cnt_next   = '0;
                    end
                end
            end
            CHECK: begin
                if (tgt_alive) begin
                    state_next = SWITCH;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = DONE;
                    fail_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SWITCH: begin
                sel_next   = tgt_reg;
                cnt_next   = '0;
                state_next = SETTLE;
            end
            SETTLE: begin
                // A dropout during settle degrades the result but the select stays put.
                if (!tgt_alive) begin
                    fail_next = 1'b1;
                end
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = DONE;
                    cur_next   = tgt_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tgt_reg   <= 1'b1;
            sel_reg   <= 1'b1;
            cur_reg   <= 1'b1;
            fail_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tgt_reg   <= tgt_next;
            sel_reg   <= sel_next;
            cur_reg   <= cur_next;
            fail_reg  <= fail_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == DONE) && fail_reg;
    assign sel_clk1  = sel_reg;
    assign cur_sel   = cur_reg;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Randomized bench for clk_switch_ctrl: each request gets a pre-generated alive waveform,
// and the expected per-cycle outputs are derived from that waveform with plain arithmetic.
module tb_clk_switch_ctrl;

    localparam int S = 16;
    localparam int T = 64;

    logic clk = 1'b0;
    logic rst, req_valid, req_sel, clk1_alive, clk2_alive;
    logic req_ready, sel_clk1, cur_sel, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic a1 [0:127];
    logic a2 [0:127];

    clk_switch_ctrl #(.SETTLE_CYCLES(S), .ALIVE_TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .clk1_alive (clk1_alive),
        .clk2_alive (clk2_alive),
        .sel_clk1   (sel_clk1),
        .cur_sel    (cur_sel),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_busy, input logic e_done,
                              input logic e_err, input logic e_sel, input logic e_cur);
        check_val({tag, ".busy"},  busy,      e_busy);
        check_val({tag, ".ready"}, req_ready, !e_busy);
        check_val({tag, ".done"},  done,      e_done);
        check_val({tag, ".err"},   err,       e_err);
        check_val({tag, ".sel"},   sel_clk1,  e_sel);
        check_val({tag, ".cur"},   cur_sel,   e_cur);
    endtask

    logic cur_m;
    logic tgt;
    int   mode, kk, jsw, jd, gap;
    logic err_m, switching;

    function automatic logic ta(input int j);
        return tgt ? a1[j] : a2[j];
    endfunction

    task automatic set_ta(input int j, input logic v);
        if (tgt) a1[j] = v;
        else     a2[j] = v;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b1; req_sel = 1'b0; clk1_alive = 1'b1; clk2_alive = 1'b1;
        // Reset with a simultaneous request: the request must be dropped.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        @(negedge clk); rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cur_m = 1'b1;

        for (int t = 0; t < 60; t++) begin
            mode = (t < 5) ? t : int'($urandom_range(0, 4));
            tgt  = (mode == 0) ? cur_m : !cur_m;
            for (int j = 0; j < 128; j++) begin
                a1[j] = 1'($urandom_range(0, 1));
                a2[j] = 1'($urandom_range(0, 1));
            end
            case (mode)
                1: for (int j = 0; j < 128; j++) set_ta(j, 1'b1);
                2: begin
                    kk = $urandom_range(1, 80);
                    for (int j = 0; j < 128; j++) set_ta(j, j >= kk);
                end
                3: begin
                    kk = $urandom_range(2, S + 3);
                    for (int j = 0; j < 128; j++) set_ta(j, j != kk);
                end
                4: for (int j = 0; j < 128; j++) set_ta(j, 1'b0);
                default: ;
            endcase

            // Expected outcome from the alive waveform.
            switching = 1'b0; err_m = 1'b0; jsw = -1;
            if (tgt == cur_m) begin
                jd = 0;
            end else begin
                for (int j = 1; j <= T; j++)
                    if (jsw < 0 && ta(j)) jsw = j;
                if (jsw < 0) begin
                    jd = T; err_m = 1'b1;
                end else begin
                    switching = 1'b1;
                    jd = jsw + 1 + S;
                    for (int j = jsw + 2; j <= jsw + 1 + S; j++)
                        if (!ta(j)) err_m = 1'b1;
                end
            end

            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                req_valid = 1'b0; req_sel = 1'($urandom_range(0, 1));
                clk1_alive = 1'($urandom_range(0, 1)); clk2_alive = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                check_outs("idle", 1'b0, 1'b0, 1'b0, cur_m, cur_m);
            end

            for (int j = 0; j <= jd + 1; j++) begin
                @(negedge clk);
                if (j == 0) begin
                    req_valid = 1'b1; req_sel = tgt;
                end else begin
                    // Requests presented while busy must be ignored.
                    req_valid = 1'($urandom_range(0, 1)); req_sel = 1'($urandom_range(0, 1));
                end
                clk1_alive = a1[j]; clk2_alive = a2[j];
                @(posedge clk); #1;
                check_outs($sformatf("txn%0d_m%0d_j%0d", t, mode, j),
                           j <= jd, j == jd, (j == jd) && err_m,
                           (switching && j >= jsw + 1) ? tgt : cur_m,
                           (switching && j >= jd) ? tgt : cur_m);
            end
            $display("txn %0d mode %0d tgt %0d done_at %0d err %0d", t, mode, tgt, jd, err_m);
            if (switching) cur_m = tgt;
            @(negedge clk); req_valid = 1'b0;
            @(posedge clk); #1;
            check_outs("settled_idle", 1'b0, 1'b0, 1'b0, cur_m, cur_m);
        end

        // Reset mid-SETTLE after a switch toward clk2.
        @(negedge clk); rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; req_valid = 1'b1; req_sel = 1'b0; clk2_alive = 1'b1;
        @(posedge clk); #1;
        check_outs("rst_accept", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        check_outs("rst_in_settle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b1; req_valid = 1'b1; req_sel = 1'b0;
        @(posedge clk); #1;
        check_outs("rst_abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check_outs("rst_after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        $display("txn reset_abort checked");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
